// File: rtl/uart_pkg.sv
// Shared types and widths for the UART message streamer and its helpers.
package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int MSG_COUNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2,
    GAP  = 2'd3
  } uart_streamer_state_t;

endpackage

// File: rtl/uart_message_streamer_if.sv
// Byte handshake between a byte source (master) and the UART transmitter (slave).
interface uart_message_streamer_if;
  import uart_pkg::*;

  logic [BYTE_W-1:0] write_data;
  logic              write_req;
  logic              ready;

  modport master (output write_data, output write_req, input ready);
  modport slave  (input write_data, input write_req, output ready);

endinterface

// File: rtl/uart_gap_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module uart_gap_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/uart_message_streamer.sv
// Streams a compile-time byte string into the UART transmitter, once or
// repeatedly, with an optional idle gap between messages and a message counter.
// Optional checksum trailer (XOR of the message bytes) when
// UART_STREAMER_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// SEND  | offering message byte idx
// CSUM  | offering the XOR trailer byte (checksum build only)
// GAP   | idle spacing before the next repeated message
module uart_message_streamer
  import uart_pkg::*;
#(
  parameter int                       MESSAGE_LEN = 15,
  parameter logic [8*MESSAGE_LEN-1:0] MESSAGE     = "Hello, world!\r\n",
  parameter int                       REPEAT      = 0,
  parameter int                       GAP_CYCLES  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       stop,
  uart_message_streamer_if.master    tx,
  output logic                       busy,
  output logic                       done,
  output logic [MSG_COUNT_W-1:0]     msg_count
);

  localparam int                IDX_W    = $clog2(MESSAGE_LEN + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(MESSAGE_LEN - 1);
  localparam int                GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  uart_streamer_state_t        state, state_next;
  logic [IDX_W-1:0]            idx, idx_next;
  logic                        stop_pending;
  logic                        stop_seen;
  logic                        accept;
  logic                        eom;
  logic                        msg_start;
  logic                        gap_load;
  logic                        gap_zero;
  logic                        write_req;
  logic [BYTE_W-1:0]           write_data;
  logic [8*MESSAGE_LEN-1:0]    msg_shift;
  logic [BYTE_W-1:0]           msg_byte;

`ifdef UART_STREAMER_CHECKSUM_EN
  logic [BYTE_W-1:0]           csum;
`endif

  // Byte idx 0 is the most significant byte of MESSAGE.
  assign msg_shift = MESSAGE << (BYTE_W * int'(idx));
  assign msg_byte  = msg_shift[8*MESSAGE_LEN-1 -: BYTE_W];

  assign accept    = write_req & tx.ready;
  assign stop_seen = stop_pending | stop;

  assign tx.write_req  = write_req;
  assign tx.write_data = write_data;
  assign busy          = (state != IDLE);

  uart_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (gap_load),
    .load_value (GAP_LOAD),
    .zero       (gap_zero)
  );

  // Next-state, index and end-of-message decode; byte outputs come from state/idx only.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    eom        = 1'b0;
    msg_start  = 1'b0;
    gap_load   = 1'b0;
    write_req  = 1'b0;
    write_data = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next = SEND;
          idx_next   = '0;
          msg_start  = 1'b1;
        end
      end
      SEND: begin
        write_req  = 1'b1;
        write_data = msg_byte;
        if (accept) begin
          if (idx == LAST_IDX) begin
            idx_next = '0;
`ifdef UART_STREAMER_CHECKSUM_EN
            state_next = CSUM;
`else
            eom = 1'b1;
`endif
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
`ifdef UART_STREAMER_CHECKSUM_EN
      CSUM: begin
        write_req  = 1'b1;
        write_data = csum;
        if (accept) begin
          eom = 1'b1;
        end
      end
`endif
      GAP: begin
        // A stop aborts the gap before any byte of the next message appears.
        if (stop_seen) begin
          state_next = IDLE;
        end else if (gap_zero) begin
          state_next = SEND;
          idx_next   = '0;
          msg_start  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (eom) begin
      idx_next = '0;
      if ((REPEAT != 0) && !stop_seen) begin
        if (GAP_CYCLES > 0) begin
          state_next = GAP;
          gap_load   = 1'b1;
        end else begin
          state_next = SEND;
          msg_start  = 1'b1;
        end
      end else begin
        state_next = IDLE;
      end
    end
  end

  // Registered FSM state, byte index, stop latch, done pulse and message counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx          <= '0;
      stop_pending <= 1'b0;
      done         <= 1'b0;
      msg_count    <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      done  <= eom;
      if (eom) begin
        msg_count <= msg_count + MSG_COUNT_W'(1);
      end
      if (state == IDLE) begin
        stop_pending <= start & stop;
      end else if (state_next == IDLE) begin
        stop_pending <= 1'b0;
      end else if (stop) begin
        stop_pending <= 1'b1;
      end
    end
  end

`ifdef UART_STREAMER_CHECKSUM_EN
  // Running XOR of accepted message bytes, cleared as each message begins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csum <= '0;
    end else if (msg_start) begin
      csum <= '0;
    end else if ((state == SEND) && accept) begin
      csum <= csum ^ msg_byte;
    end
  end
`endif

endmodule

// File: tb/tb_uart_message_streamer.sv
// Directed + randomized bench for uart_message_streamer. Three instances:
// "AB" one-shot, "AB" repeating with a 3-cycle gap, and a 5-byte binary
// message (contains NULs) repeating back-to-back. Honours
// UART_STREAMER_CHECKSUM_EN by appending the XOR trailer to the expected stream.
module tb_uart_message_streamer;

  logic clk;
  logic reset_n;
  logic start_a, stop_a, busy_a, done_a;
  logic start_b, stop_b, busy_b, done_b;
  logic start_c, stop_c, busy_c, done_c;
  logic [15:0] msg_count_a, msg_count_b, msg_count_c;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_ab[$];
  logic [7:0] exp_c[$];

  uart_message_streamer_if ia();
  uart_message_streamer_if ib();
  uart_message_streamer_if ic();

  uart_message_streamer #(.MESSAGE_LEN(2), .MESSAGE(16'h4142), .REPEAT(0), .GAP_CYCLES(0)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .stop(stop_a), .tx(ia.master),
    .busy(busy_a), .done(done_a), .msg_count(msg_count_a));

  uart_message_streamer #(.MESSAGE_LEN(2), .MESSAGE(16'h4142), .REPEAT(1), .GAP_CYCLES(3)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .stop(stop_b), .tx(ib.master),
    .busy(busy_b), .done(done_b), .msg_count(msg_count_b));

  uart_message_streamer #(.MESSAGE_LEN(5), .MESSAGE(40'h005A00FF0D), .REPEAT(1), .GAP_CYCLES(0)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .stop(stop_c), .tx(ic.master),
    .busy(busy_c), .done(done_c), .msg_count(msg_count_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Append the XOR trailer the checksum build sends after each message.
  task automatic add_trailer(inout logic [7:0] q[$]);
`ifdef UART_STREAMER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    q.push_back(x);
`endif
  endtask

  // One message on u_a. mode 0: ready=1, 1: ready 1-0-0-1, 2: random ready.
  task automatic stream_a(input int mode, input int exp_cnt);
    logic [7:0] q[$];
    logic       stall;
    logic [7:0] held;
    bit         fin;
    q = exp_ab;
    stall = 1'b0;
    held = 8'h00;
    fin = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (c == 0 || mode == 0) chk("a_req_active", 32'(ia.write_req), 32'(1));
      if (stall) begin
        chk("a_hold_req", 32'(ia.write_req), 32'(1));
        chk("a_hold_data", 32'(ia.write_data), 32'(held));
      end
      case (mode)
        0:       ia.ready = 1'b1;
        1:       ia.ready = (c == 1 || c == 2) ? 1'b0 : 1'b1;
        default: ia.ready = 1'($urandom_range(0, 1));
      endcase
      if (ia.write_req && ia.ready) begin
        chk("a_byte", 32'(ia.write_data), 32'(q.pop_front()));
        stall = 1'b0;
        if (q.size() == 0) fin = 1'b1;
      end else begin
        stall = ia.write_req;
        held  = ia.write_data;
      end
      tick();
    end
    chk("a_complete", 32'(fin), 32'(1));
    chk("a_done", 32'(done_a), 32'(1));
    chk("a_count", 32'(msg_count_a), 32'(exp_cnt));
    chk("a_busy_end", 32'(busy_a), 32'(0));
    chk("a_req_end", 32'(ia.write_req), 32'(0));
    tick();
    chk("a_done_pulse", 32'(done_a), 32'(0));
  endtask

  initial begin
    int lt, lc, per, acc;
    logic       stall;
    logic [7:0] held;
    bit         stopped;

    reset_n = 1'b0;
    start_a = 1'b0; stop_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0;
    start_c = 1'b0; stop_c = 1'b0;
    ia.ready = 1'b0; ib.ready = 1'b0; ic.ready = 1'b0;

    exp_ab.push_back(8'h41);
    exp_ab.push_back(8'h42);
    add_trailer(exp_ab);
    exp_c.push_back(8'h00);
    exp_c.push_back(8'h5A);
    exp_c.push_back(8'h00);
    exp_c.push_back(8'hFF);
    exp_c.push_back(8'h0D);
    add_trailer(exp_c);
    lt  = exp_ab.size();
    lc  = exp_c.size();
    per = lt + 3;

    repeat (3) tick();
    chk("rst_a_req", 32'(ia.write_req), 32'(0));
    chk("rst_a_data", 32'(ia.write_data), 32'(0));
    chk("rst_a_busy", 32'(busy_a), 32'(0));
    chk("rst_a_done", 32'(done_a), 32'(0));
    chk("rst_a_count", 32'(msg_count_a), 32'(0));
    chk("rst_b_req", 32'(ib.write_req), 32'(0));
    chk("rst_b_busy", 32'(busy_b), 32'(0));
    chk("rst_b_count", 32'(msg_count_b), 32'(0));
    chk("rst_c_req", 32'(ic.write_req), 32'(0));
    chk("rst_c_busy", 32'(busy_c), 32'(0));
    chk("rst_c_count", 32'(msg_count_c), 32'(0));
    reset_n = 1'b1;
    tick();
    tick();

    // One-shot, back-pressure, random ready.
    stream_a(0, 1);
    stream_a(1, 2);
    stream_a(2, 3);

    // Repeat with a 3-cycle gap; start while busy must be ignored; stop in a gap.
    ib.ready = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k <= 3 * per + lt; k++) begin
      chk("b_req", 32'(ib.write_req), 32'((k % per) < lt));
      if ((k % per) < lt) chk("b_data", 32'(ib.write_data), 32'(exp_ab[k % per]));
      chk("b_done", 32'(done_b), 32'(k >= lt && ((k - lt) % per) == 0));
      chk("b_count", 32'(msg_count_b), 32'(k >= lt ? (k - lt) / per + 1 : 0));
      start_b = (k == 1);
      stop_b  = (k == 3 * per + lt);
      tick();
    end
    start_b = 1'b0;
    stop_b  = 1'b0;
    chk("b_gap_stop_busy", 32'(busy_b), 32'(0));
    chk("b_gap_stop_req", 32'(ib.write_req), 32'(0));
    chk("b_gap_stop_count", 32'(msg_count_b), 32'(4));

    // Stop during byte 0 of a repeating message: message still completes, then idle.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_mid_req0", 32'(ib.write_req), 32'(1));
    chk("b_mid_data0", 32'(ib.write_data), 32'(exp_ab[0]));
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
    for (int i = 1; i < lt; i++) begin
      chk("b_mid_req", 32'(ib.write_req), 32'(1));
      chk("b_mid_data", 32'(ib.write_data), 32'(exp_ab[i]));
      tick();
    end
    chk("b_mid_done", 32'(done_b), 32'(1));
    chk("b_mid_busy", 32'(busy_b), 32'(0));
    chk("b_mid_count", 32'(msg_count_b), 32'(5));
    repeat (6) begin
      tick();
      chk("b_mid_quiet", 32'(ib.write_req), 32'(0));
    end

    // Binary message, back-to-back repeats under random ready, stop inside message 3.
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    acc = 0;
    stall = 1'b0;
    held = 8'h00;
    stopped = 1'b0;
    for (int c = 0; c < 600 && busy_c; c++) begin
      if (stall) begin
        chk("c_hold_req", 32'(ic.write_req), 32'(1));
        chk("c_hold_data", 32'(ic.write_data), 32'(held));
      end
      ic.ready = ($urandom_range(0, 3) != 0);
      if (ic.write_req && ic.ready) begin
        chk("c_byte", 32'(ic.write_data), 32'(exp_c[acc % lc]));
        acc++;
        stall = 1'b0;
      end else begin
        stall = ic.write_req;
        held  = ic.write_data;
      end
      stop_c = 1'b0;
      if (!stopped && acc == 2 * lc + 1) begin
        stop_c  = 1'b1;
        stopped = 1'b1;
      end
      tick();
    end
    stop_c = 1'b0;
    chk("c_idle_after_stop", 32'(busy_c), 32'(0));
    chk("c_total_bytes", 32'(acc), 32'(3 * lc));
    chk("c_done", 32'(done_c), 32'(1));
    chk("c_count", 32'(msg_count_c), 32'(3));

    // start and stop together in IDLE on a repeating instance: exactly one message.
    ic.ready = 1'b1;
    start_c = 1'b1;
    stop_c  = 1'b1;
    tick();
    start_c = 1'b0;
    stop_c  = 1'b0;
    for (int i = 0; i < lc; i++) begin
      chk("c_one_req", 32'(ic.write_req), 32'(1));
      chk("c_one_data", 32'(ic.write_data), 32'(exp_c[i]));
      tick();
    end
    chk("c_one_done", 32'(done_c), 32'(1));
    chk("c_one_busy", 32'(busy_c), 32'(0));
    chk("c_one_count", 32'(msg_count_c), 32'(4));
    tick();
    chk("c_one_quiet", 32'(ic.write_req), 32'(0));

    // Asynchronous reset while a byte is stalled.
    ia.ready = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("rst_mid_req_pre", 32'(ia.write_req), 32'(1));
    chk("rst_mid_data_pre", 32'(ia.write_data), 32'(8'h41));
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_req", 32'(ia.write_req), 32'(0));
    chk("rst_mid_data", 32'(ia.write_data), 32'(0));
    chk("rst_mid_busy", 32'(busy_a), 32'(0));
    chk("rst_mid_count", 32'(msg_count_a), 32'(0));
    chk("rst_mid_count_c", 32'(msg_count_c), 32'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    stream_a(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_message_streamer.md
# uart_message_streamer

Parametrised message source for the UART transmit path. It sends a compile-time byte string, once or repeatedly, into `uart_transmitter` over the write_data/write_req/ready handshake. Relative to the fixed hello-world top it adds:
- start/stop control;
- binary-safe messages, so NUL bytes are sent rather than acting as a terminator;
- a programmable inter-message gap;
- a message counter;
- an optional checksum trailer.

It sits between board-level control logic and `uart_transmitter`.

## Interface
- MESSAGE_LEN, default 15: number of bytes in MESSAGE; must be ≥1.
- MESSAGE, default "Hello, world!\r\n": packed `[8*MESSAGE_LEN-1:0]`; most significant byte is sent first.
- REPEAT, default 0: 1 restarts the message automatically after each completion.
- GAP_CYCLES, default 0: idle clk cycles between repeated messages; 0 means back-to-back.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle request to begin streaming; honoured only in IDLE.
- stop  in  1  request to halt at the next message boundary.
- write_data  out  8  byte offered to the transmitter.
- write_req  out  1  write_data is valid.
- ready  in  1  transmitter accepts the byte when write_req && ready.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse after each completed message.
- msg_count  out  16  number of completed messages; wraps 0xFFFF→0.

## Operation
- States: IDLE, SEND, CSUM (only when the checksum feature is compiled in), GAP.
- IDLE:
  - start → SEND with idx=0; stop_pending is cleared unless stop is also high.
- SEND:
  - write_req=1; write_data=MESSAGE byte idx, with idx 0 = bits `[8*MESSAGE_LEN-1 -: 8]`.
  - On accept, idx increments.
  - On accept at idx=MESSAGE_LEN-1: go to CSUM, or to end-of-message if the checksum feature is absent.
- End-of-message actions:
  - msg_count++ and done pulses.
  - If REPEAT && !stop_pending: go to GAP when GAP_CYCLES>0, otherwise go directly to SEND with idx=0.
  - Otherwise go to IDLE and clear stop_pending.
- GAP:
  - The counter loads GAP_CYCLES-1 on entry and counts down; at 0 → SEND with idx=0.
  - Any stop (pending, or arriving during GAP) → IDLE on the next edge; no partial message is started.
- Handshake rules:
  - While write_req && !ready, write_data and write_req hold stable.
  - write_req never drops without an accept, except on reset.
- stop:
  - Latched into stop_pending in any non-IDLE state.
  - Never truncates a message; the current message, including its checksum, always completes.
- Other boundary behaviour:
  - start while busy is ignored.
  - start && stop together in IDLE: exactly one message is sent, then IDLE.
- Reset (including mid-message): state=IDLE, idx=0, write_req=0, write_data=0, busy=0, done=0, msg_count=0, stop_pending=0. A byte in flight is abandoned.

## Timing
- Start latency: start high at edge N → write_req=1 during cycle N+1.
- Throughput: with ready held high, one byte per cycle, so a message occupies MESSAGE_LEN cycles, or MESSAGE_LEN+1 with the checksum.
- Final accept at edge M:
  - done=1 during cycle M+1.
  - msg_count is updated from cycle M+1.
- Next message with REPEAT=1, GAP_CYCLES=G:
  - write_req=0 during cycles M+1…M+G.
  - Byte 0 is offered at M+G+1.
  - With G=0, byte 0 is offered at M+1, so there are no idle cycles.
- REPEAT=0: busy=0 from cycle M+1.
- Output drive: write_data and write_req are decoded from registered state and idx only; there is no combinational path from ready or start.

## Configuration
- Macro: UART_STREAMER_CHECKSUM_EN.
- Defined:
  - A running XOR of accepted message bytes is kept; it is cleared at the start of each message.
  - After the last message byte, CSUM offers the XOR value as one extra byte.
  - End-of-message actions occur on its accept.
- Undefined:
  - The CSUM state and XOR register do not exist.
  - End-of-message actions occur on the accept of the last message byte.

## Structure
- Package `uart_pkg`:
  - state enum `uart_streamer_state_t` (IDLE, SEND, CSUM, GAP);
  - localparam BYTE_W=8;
  - localparam MSG_COUNT_W=16.
- Index width: `$clog2(MESSAGE_LEN+1)`.
- Gap counter width: `$clog2(GAP_CYCLES+1)`, minimum 1.
- Sub-module: `uart_gap_timer`, a loadable down-counter with a zero flag. It is reused later for the transmitter inter-frame spacing.
- The top-level board wrapper instantiates reset_synchronizer, uart_message_streamer and uart_transmitter.

## Test plan
- One-shot, ready constant 1: MESSAGE="AB", REPEAT=0, start → 0x41 then 0x42 on consecutive cycles, done on the next cycle, msg_count=1, busy=0.
- Back-pressure: ready toggles 1-0-0-1 → write_data holds 0x42 through the stall cycles; no byte is duplicated or dropped.
- Repeat with gap: REPEAT=1, GAP_CYCLES=3, ready=1 → exactly 3 cycles with write_req=0 between messages; msg_count increments every 5 cycles.
- Mid-message stop: stop asserted during byte 0 with REPEAT=1 → byte 1 still sent, done pulses, IDLE, no further write_req. stop during GAP → IDLE next cycle.
- Checksum (macro defined): "AB" → 0x41, 0x42, 0x03, then done.
- Async reset asserted while write_req=1 and ready=0 → write_req=0 immediately; msg_count=0; a fresh start sends 0x41 first.
